// File: rtl/lat_mem_pkg.sv
// Shared encodings for the latency-modelled memory: FSM states and the
// externally visible Free/Stall status codes.
package lat_mem_pkg;

  typedef logic [1:0] fsm_t;

  localparam fsm_t FREE        = 2'd0;
  localparam fsm_t STALL_READ  = 2'd1;
  localparam fsm_t STALL_WRITE = 2'd2;

  localparam logic [2:0] STATE_FREE  = 3'b000;
  localparam logic [2:0] STATE_STALL = 3'b111;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage with a combinational 4-byte little-endian read port
// and a byte-enabled 4-byte write port. Contents are never reset.
module mem_byte_array #(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i
);

  logic [7:0] mem_q [DEPTH];

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [AW-1:0] idx;
    assign idx = addr_i + AW'(g);
    assign rdata_o[8*g +: 8] = mem_q[idx];
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i + AW'(i)] <= wdata_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/lat_memory.sv
// Memory model with fixed read/write latency: a request is latched in FREE,
// the block stalls for LAT cycles, then commits and pulses done for one cycle.
module lat_memory
  import lat_mem_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int READ_LAT  = 4,
  parameter int WRITE_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [3:0]  be,
  input  logic [31:0] wd,
  input  logic [31:0] addr,
  output logic [31:0] rd,
  output logic [2:0]  state,
  output logic        done,
  output logic        err
);

  localparam int AW      = $clog2(DEPTH);
  localparam int MAX_LAT = maxInt(READ_LAT, WRITE_LAT);
  localparam int CW      = $clog2(MAX_LAT) + 1;

  localparam logic [CW-1:0] RD_LAST  = CW'(READ_LAT - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WRITE_LAT - 1);
  localparam logic [31:0]   MAX_ADDR = 32'(DEPTH - 4);

  if (READ_LAT < 1 || WRITE_LAT < 1) begin : g_bad_lat
    $error("lat_memory: READ_LAT and WRITE_LAT must be >= 1");
  end
  if (DEPTH < 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lat_memory: DEPTH must be a power of two >= 8");
  end

  fsm_t          fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   rd_q, rd_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          outOfRange;
  logic          memWe;
  logic [31:0]   memRdata;

  assign outOfRange = addr_q > MAX_ADDR;

  mem_byte_array #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk),
    .addr_i  (addr_q[AW-1:0]),
    .rdata_o (memRdata),
    .we_i    (memWe),
    .be_i    (be_q),
    .wdata_i (wd_q)
  );

  // Commit happens on the last stall edge; reset low suppresses a pending write.
  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    wd_d   = wd_q;
    be_d   = be_q;
    rd_d   = rd_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    memWe  = 1'b0;
    case (fsm_q)
      FREE: begin
        if (MemRead || MemWrite) begin
          fsm_d  = MemRead ? STALL_READ : STALL_WRITE;
          cnt_d  = '0;
          addr_d = addr;
          wd_d   = wd;
          be_d   = be;
        end
      end
      STALL_READ: begin
        if (cnt_q == RD_LAST) begin
          fsm_d  = FREE;
          done_d = 1'b1;
          err_d  = outOfRange;
          rd_d   = outOfRange ? '0 : memRdata;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STALL_WRITE: begin
        if (cnt_q == WR_LAST) begin
          fsm_d  = FREE;
          done_d = 1'b1;
          err_d  = outOfRange;
          memWe  = rst && !outOfRange;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: fsm_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q  <= FREE;
      cnt_q  <= '0;
      rd_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      be_q   <= '0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      done_q <= done_d;
      err_q  <= err_d;
      addr_q <= addr_d;
      wd_q   <= wd_d;
      be_q   <= be_d;
    end
  end

  assign state = (fsm_q == FREE) ? STATE_FREE : STATE_STALL;
  assign rd    = rd_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_lat_memory.sv
// Self-checking bench for lat_memory: directed scenarios plus random traffic
// compared against a byte-array reference model.
module tb_lat_memory;

  localparam int DEPTH     = 1024;
  localparam int READ_LAT  = 4;
  localparam int WRITE_LAT = 8;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] addr;
  logic [31:0] rd;
  logic [2:0]  state;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [7:0]  model [DEPTH];
  logic [31:0] lastRd;

  lat_memory #(
    .DEPTH     (DEPTH),
    .READ_LAT  (READ_LAT),
    .WRITE_LAT (WRITE_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .be       (be),
    .wd       (wd),
    .addr     (addr),
    .rd       (rd),
    .state    (state),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic modelInRange(input logic [31:0] a);
    return a <= 32'(DEPTH - 4);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (!modelInRange(a)) return 32'h0;
    return {model[a+3], model[a+2], model[a+1], model[a]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one request at the current point (must be before a posedge), scrambles
  // the inputs once accepted, then counts stall cycles and checks completion.
  task automatic applyStimulus(input logic rdReq, input logic wrReq, input logic [31:0] a,
                               input logic [31:0] data, input logic [3:0] byteEn, input string tag);
    int          stalls;
    int          lat;
    logic        isRead;
    logic [31:0] expRd;
    isRead   = rdReq;
    lat      = isRead ? READ_LAT : WRITE_LAT;
    MemRead  = rdReq;
    MemWrite = wrReq;
    addr     = a;
    wd       = data;
    be       = byteEn;
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr     = $urandom;
    wd       = $urandom;
    be       = 4'($urandom);
    stalls   = 0;
    forever begin
      @(negedge clk);
      if (state !== 3'b111 || stalls > 64) break;
      stalls++;
    end
    if (isRead) begin
      expRd  = modelRead(a);
      lastRd = expRd;
    end else begin
      expRd = lastRd;
      if (modelInRange(a)) begin
        for (int i = 0; i < 4; i++) begin
          if (byteEn[i]) model[a+i] = data[8*i +: 8];
        end
      end
    end
    checkOutput({tag, "_stalls"}, 32'(stalls), 32'(lat));
    checkOutput({tag, "_state"}, {29'b0, state}, 32'h0);
    checkOutput({tag, "_done"}, {31'b0, done}, 32'h1);
    checkOutput({tag, "_err"}, {31'b0, err}, {31'b0, !modelInRange(a)});
    checkOutput({tag, "_rd"}, rd, expRd);
  endtask

  task automatic idleCycle(input string tag);
    @(negedge clk);
    checkOutput({tag, "_doneLow"}, {31'b0, done}, 32'h0);
    checkOutput({tag, "_stateFree"}, {29'b0, state}, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] snap;
    int          kind;

    rst      = 1'b0;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    be       = 4'hF;
    wd       = 32'h0;
    addr     = 32'h10;
    lastRd   = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", {29'b0, state}, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'h0);
    checkOutput("reset_err", {31'b0, err}, 32'h0);
    checkOutput("reset_rd", rd, 32'h0);
    MemRead = 1'b0;
    rst     = 1'b1;
    idleCycle("postReset");

    // Fill the whole array so every later read has a known reference value.
    for (int w = 0; w < DEPTH; w += 4) begin
      applyStimulus(1'b0, 1'b1, 32'(w), $urandom, 4'hF, "preload");
    end

    applyStimulus(1'b0, 1'b1, 32'h10, 32'h44332211, 4'hF, "init10");
    idleCycle("init10");
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "read10");
    checkOutput("read10_const", rd, 32'h44332211);
    idleCycle("read10");

    applyStimulus(1'b0, 1'b1, 32'h20, 32'h0, 4'hF, "clear20");
    applyStimulus(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "beWrite20");
    checkOutput("beWrite20_rdHeld", rd, 32'h44332211);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, "read20");
    checkOutput("read20_const", rd, 32'h00BB00DD);

    // Back-to-back: next read issued in the done cycle.
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "b2bRead10");
    checkOutput("b2bRead10_const", rd, 32'h44332211);
    idleCycle("b2b");

    applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "priority10");
    checkOutput("priority10_const", rd, 32'h44332211);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "priorityReread");
    checkOutput("priorityReread_const", rd, 32'h44332211);

    applyStimulus(1'b1, 1'b0, 32'(DEPTH - 3), 32'h0, 4'h0, "oorRead");
    checkOutput("oorRead_const", rd, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'(DEPTH - 3), 32'h12345678, 4'hF, "oorWrite");
    applyStimulus(1'b1, 1'b0, 32'(DEPTH - 4), 32'h0, 4'h0, "topWord");
    applyStimulus(1'b1, 1'b0, 32'h1E3, 32'h0, 4'h0, "unaligned");
    idleCycle("oor");

    // Abort a write with reset partway through its stall.
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, "pre30");
    snap     = lastRd;
    MemWrite = 1'b1;
    addr     = 32'h30;
    wd       = 32'hFFFFFFFF;
    be       = 4'hF;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("midWrite_stall", {29'b0, state}, 32'h7);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_state", {29'b0, state}, 32'h0);
    checkOutput("abort_done", {31'b0, done}, 32'h0);
    checkOutput("abort_rd", rd, 32'h0);
    rst    = 1'b1;
    lastRd = 32'h0;
    idleCycle("abort");
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, "post30");
    checkOutput("post30_unchanged", rd, snap);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = 32'(DEPTH - 8 + $urandom_range(0, 10));
      else                           a = 32'($urandom_range(0, DEPTH - 1));
      applyStimulus(kind != 2, kind >= 2, a, $urandom, 4'($urandom), "random");
      if ($urandom_range(0, 1) == 1) idleCycle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
